isq_issue_read_stage: RTL and testbench
=======================================

Name: isq_issue_read_stage

Overview:
- Sits directly downstream of the integer issue queue dequeue port; consumes the 248-bit packed uop the queue selects.
- Reads two physical-register-file operands and resolves same-cycle writeback bypass.
- Forms final src1/src2 operands and presents the uop to the execute unit through a two-stage valid/ready pipeline.
- Kills in-flight uops younger than a ROB flush point.

Parameters:
- DATA_WIDTH, 248, packed uop width (field map fixed in isu_pkg).
- ROB_SIZE_LOG, 6, robid width is ROB_SIZE_LOG+1 (MSB = wrap bit).
- PREG_WIDTH, 6, physical register index width.
- XLEN, 64, operand width.

Ports:
- clock, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- isq_valid, in, 1, issue queue has a uop.
- isq_ready, out, 1, this stage accepts a uop.
- isq_data, in, DATA_WIDTH, packed uop: robid[247:241], pc[240:177], prs1[116:111], prs2[110:105], src1_is_reg[104], src2_is_reg[103], imm[102:39].
- prf_rd0_idx, out, PREG_WIDTH, PRF read port 0 address (prs1).
- prf_rd1_idx, out, PREG_WIDTH, PRF read port 1 address (prs2).
- prf_rd0_data, in, XLEN, port 0 data, valid the cycle after the address.
- prf_rd1_data, in, XLEN, port 1 data, valid the cycle after the address.
- wb_valid, in, 1, writeback this cycle.
- wb_prd, in, PREG_WIDTH, writeback destination.
- wb_data, in, XLEN, writeback value.
- flush_valid, in, 1, ROB rollback.
- flush_robid, in, ROB_SIZE_LOG+1, flush point; strictly younger uops die.
- exu_valid, out, 1, uop to execute.
- exu_ready, in, 1, execute accepts.
- exu_data, out, DATA_WIDTH, uop passthrough.
- exu_src1, out, XLEN, resolved operand 1.
- exu_src2, out, XLEN, resolved operand 2.

Behaviour:
- Reset: s1_valid=0, s2_valid=0.
  - exu_valid=0, exu_src1/exu_src2/exu_data=0.
  - isq_ready=1, prf_rd*_idx=0.
- prf_rd0_idx = isq_data prs1 and prf_rd1_idx = isq_data prs2, combinational, driven every cycle regardless of handshake.
- Accept at cycle T when isq_valid && isq_ready.
  - S1 loads the uop.
  - Per source: if wb_valid && wb_prd==prs at T, latch wb_data and set byp flag.
- S1 operand selection, per source, in this priority:
  1. prs==0 gives 0.
  2. stored flag set gives the stored value.
  3. byp flag set gives the bypass value.
  4. Otherwise prf_rd*_data.
- At T+1, if S1 does not advance, the selected values are written to the stored registers and stored flags are set. PRF data is not valid after T+1.
- Final operands:
  - src1 = src1_is_reg ? operand1 : pc (zero-extended).
  - src2 = src2_is_reg ? operand2 : imm.
- s1_advance = s1_valid && (!s2_valid || exu_ready). S2 loads the uop and final operands.
- isq_ready = !s1_valid || s1_advance. Throughput is 1 uop/cycle.
  - Minimum latency: accept at T, exu_valid at T+2.
- exu handshake completes on exu_valid && exu_ready. S2 holds its contents stable while stalled.
- Younger test: younger(id) = (id[MSB]^flush_robid[MSB]) ^ (id[low] > flush_robid[low]). Equal robid is not younger.
- Flush cycle, with flush_valid set:
  - S2: if younger, it is cleared and exu_valid is forced 0 combinationally in that cycle. No exu handshake occurs.
  - S1: if younger, it is cleared and does not move to S2.
  - Incoming uop: if younger, it is not loaded (isq_ready still asserted, so the queue drops it).
  - Older uops continue normally, including advancing in the flush cycle.
- Simultaneous events:
  - S2 drain and S1 advance in the same cycle are legal.
  - Accept with S1 advance in the same cycle is legal.
- Reset mid-operation: all valids clear immediately. Stored and bypass flags clear.

Decomposition:
- Shared package isu_pkg holds:
  - uop field offset localparams (robid, pc, prs1, prs2, src_is_reg, imm).
  - ROB_SIZE_LOG.
  - function robid_younger(id, flush_id).
- Sub-module iss_operand_slot, instantiated twice. It holds the byp/stored registers and flags and implements the priority mux, including the prs==0 zeroing.

Test Plan:
- Back-to-back: 3 uops with prs1=5/prs2=6, PRF returns 0x11/0x22, exu_ready=1. Required response: exu_valid at T+2, T+3, T+4 with src1=0x11, src2=0x22, and isq_ready constantly 1.
- Bypass: accept with prs1=9 while wb_valid, wb_prd=9, wb_data=0xABCD, PRF returns a stale 0x0. Required response: exu_src1=0xABCD.
- Stall hold: exu_ready=0 for 5 cycles after accept, PRF data 0x77 only at T+1, then garbage. Required response: exu_src1 stays 0x77, exu_data is unchanged, and isq_ready drops once S1 is full.
- Immediates/zero: src2_is_reg=0, imm=0xFFFF_FFFF_FFFF_FFF0, src1_is_reg=1, prs1=0. Required response: src1=0, src2=0xFFFF_FFFF_FFFF_FFF0.
- Flush with wrap: S2 robid=0x7E, S1 robid=0x01, flush_robid=0x7F. Required response: S2 survives and issues; S1 (younger via wrap bit) is dropped.
- Flush kill plus equality: S2 robid=0x10, flush_robid=0x10, S1 robid=0x11, incoming uop robid=0x12. Required response: only 0x10 reaches exu; the pipe is empty afterwards.

Source files
------------

// File: rtl/isu_pkg.sv
// Shared integer-issue definitions: uop field map, widths and ROB age compare.
package isu_pkg;
    localparam int DATA_WIDTH   = 248;
    localparam int ROB_SIZE_LOG = 6;
    localparam int ROBID_WIDTH  = ROB_SIZE_LOG + 1;
    localparam int PREG_WIDTH   = 6;
    localparam int XLEN         = 64;

    localparam int ROBID_LSB       = 241;
    localparam int PC_LSB          = 177;
    localparam int PRS1_LSB        = 111;
    localparam int PRS2_LSB        = 105;
    localparam int SRC1_IS_REG_BIT = 104;
    localparam int SRC2_IS_REG_BIT = 103;
    localparam int IMM_LSB         = 39;

    // Wrap bit differing flips the sense of the low-bit magnitude compare.
    function automatic logic robid_younger(input logic [ROBID_WIDTH-1:0] id,
                                           input logic [ROBID_WIDTH-1:0] flush_id);
        return (id[ROBID_WIDTH-1] ^ flush_id[ROBID_WIDTH-1]) ^
               (id[ROBID_WIDTH-2:0] > flush_id[ROBID_WIDTH-2:0]);
    endfunction
endpackage

// File: rtl/iss_operand_slot.sv
// One source operand: captures writeback bypass at accept, keeps the selected
// value once PRF read data has gone away, and resolves the operand priority.
module iss_operand_slot #(
    parameter int PREG_WIDTH = 6,
    parameter int XLEN       = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  hold,
    input  logic [PREG_WIDTH-1:0] in_prs,
    input  logic                  wb_valid,
    input  logic [PREG_WIDTH-1:0] wb_prd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [PREG_WIDTH-1:0] s1_prs,
    input  logic [XLEN-1:0]       prf_data,
    output logic [XLEN-1:0]       operand
);
    logic            byp_flag;
    logic            stored_flag;
    logic [XLEN-1:0] byp_value;
    logic [XLEN-1:0] stored_value;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byp_flag     <= 1'b0;
            stored_flag  <= 1'b0;
            byp_value    <= '0;
            stored_value <= '0;
        end else if (load) begin
            byp_flag    <= wb_valid && (wb_prd == in_prs);
            byp_value   <= wb_data;
            stored_flag <= 1'b0;
        end else if (hold) begin
            stored_flag  <= 1'b1;
            stored_value <= operand;
        end
    end

    always_comb begin
        operand = prf_data;
        if (s1_prs == '0)
            operand = '0;
        else if (stored_flag)
            operand = stored_value;
        else if (byp_flag)
            operand = byp_value;
    end
endmodule

// File: rtl/isq_issue_read_stage.sv
// Issue-read stage: PRF operand read with writeback bypass, two-entry
// valid/ready pipe into execute, and ROB-flush kill of younger uops.
module isq_issue_read_stage
    import isu_pkg::*;
#(
    parameter int DATA_WIDTH   = isu_pkg::DATA_WIDTH,
    parameter int ROB_SIZE_LOG = isu_pkg::ROB_SIZE_LOG,
    parameter int PREG_WIDTH   = isu_pkg::PREG_WIDTH,
    parameter int XLEN         = isu_pkg::XLEN
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    isq_valid,
    output logic                    isq_ready,
    input  logic [DATA_WIDTH-1:0]   isq_data,
    output logic [PREG_WIDTH-1:0]   prf_rd0_idx,
    output logic [PREG_WIDTH-1:0]   prf_rd1_idx,
    input  logic [XLEN-1:0]         prf_rd0_data,
    input  logic [XLEN-1:0]         prf_rd1_data,
    input  logic                    wb_valid,
    input  logic [PREG_WIDTH-1:0]   wb_prd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    flush_valid,
    input  logic [ROB_SIZE_LOG:0]   flush_robid,
    output logic                    exu_valid,
    input  logic                    exu_ready,
    output logic [DATA_WIDTH-1:0]   exu_data,
    output logic [XLEN-1:0]         exu_src1,
    output logic [XLEN-1:0]         exu_src2
);
    logic                  s1_valid, s2_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_advance, accept, s1_load, s2_fire;
    logic                  in_kill, s1_kill, s2_kill;
    logic [XLEN-1:0]       operand1, operand2, src1_final, src2_final;

    assign prf_rd0_idx = isq_data[PRS1_LSB +: PREG_WIDTH];
    assign prf_rd1_idx = isq_data[PRS2_LSB +: PREG_WIDTH];

    assign in_kill = flush_valid && robid_younger(isq_data[ROBID_LSB +: ROB_SIZE_LOG+1], flush_robid);
    assign s1_kill = flush_valid && s1_valid && robid_younger(s1_data[ROBID_LSB +: ROB_SIZE_LOG+1], flush_robid);
    assign s2_kill = flush_valid && s2_valid && robid_younger(exu_data[ROBID_LSB +: ROB_SIZE_LOG+1], flush_robid);

    assign s1_advance = s1_valid && (!s2_valid || exu_ready);
    assign isq_ready  = !s1_valid || s1_advance;
    assign accept     = isq_valid && isq_ready;
    assign s1_load    = accept && !in_kill;
    assign exu_valid  = s2_valid && !s2_kill;
    assign s2_fire    = exu_valid && exu_ready;

    iss_operand_slot #(.PREG_WIDTH(PREG_WIDTH), .XLEN(XLEN)) u_slot1 (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (s1_load),
        .hold     (s1_valid && !s1_advance),
        .in_prs   (isq_data[PRS1_LSB +: PREG_WIDTH]),
        .wb_valid (wb_valid),
        .wb_prd   (wb_prd),
        .wb_data  (wb_data),
        .s1_prs   (s1_data[PRS1_LSB +: PREG_WIDTH]),
        .prf_data (prf_rd0_data),
        .operand  (operand1)
    );

    iss_operand_slot #(.PREG_WIDTH(PREG_WIDTH), .XLEN(XLEN)) u_slot2 (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (s1_load),
        .hold     (s1_valid && !s1_advance),
        .in_prs   (isq_data[PRS2_LSB +: PREG_WIDTH]),
        .wb_valid (wb_valid),
        .wb_prd   (wb_prd),
        .wb_data  (wb_data),
        .s1_prs   (s1_data[PRS2_LSB +: PREG_WIDTH]),
        .prf_data (prf_rd1_data),
        .operand  (operand2)
    );

    assign src1_final = s1_data[SRC1_IS_REG_BIT] ? operand1 : s1_data[PC_LSB +: XLEN];
    assign src2_final = s1_data[SRC2_IS_REG_BIT] ? operand2 : s1_data[IMM_LSB +: XLEN];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_data  <= isq_data;
        end else if (s1_advance || s1_kill) begin
            s1_valid <= 1'b0;
        end
    end

    // A killed S1 entry still frees its slot but never reaches S2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            exu_data <= '0;
            exu_src1 <= '0;
            exu_src2 <= '0;
        end else if (s1_advance && !s1_kill) begin
            s2_valid <= 1'b1;
            exu_data <= s1_data;
            exu_src1 <= src1_final;
            exu_src2 <= src2_final;
        end else if (s2_fire || s2_kill) begin
            s2_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_isq_issue_read_stage.sv
// Bench for isq_issue_read_stage: directed scenarios plus a randomized run
// against a transaction-level reference of the two-entry pipe.
module tb_isq_issue_read_stage;
    logic         clock = 1'b0;
    logic         reset_n;
    logic         isq_valid, isq_ready;
    logic [247:0] isq_data;
    logic [5:0]   prf_rd0_idx, prf_rd1_idx;
    logic [63:0]  prf_rd0_data, prf_rd1_data;
    logic         wb_valid;
    logic [5:0]   wb_prd;
    logic [63:0]  wb_data;
    logic         flush_valid;
    logic [6:0]   flush_robid;
    logic         exu_valid, exu_ready;
    logic [247:0] exu_data;
    logic [63:0]  exu_src1, exu_src2;

    int tests = 0;
    int fails = 0;

    isq_issue_read_stage dut (
        .clock(clock), .reset_n(reset_n),
        .isq_valid(isq_valid), .isq_ready(isq_ready), .isq_data(isq_data),
        .prf_rd0_idx(prf_rd0_idx), .prf_rd1_idx(prf_rd1_idx),
        .prf_rd0_data(prf_rd0_data), .prf_rd1_data(prf_rd1_data),
        .wb_valid(wb_valid), .wb_prd(wb_prd), .wb_data(wb_data),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_data(exu_data),
        .exu_src1(exu_src1), .exu_src2(exu_src2)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        isq_valid = 0; isq_data = '0; wb_valid = 0; wb_prd = '0; wb_data = '0;
        flush_valid = 0; flush_robid = '0; exu_ready = 1;
        prf_rd0_data = '0; prf_rd1_data = '0;
    endtask

    function automatic logic [247:0] mk(input logic [6:0] rid, input logic [63:0] pc,
                                        input logic [5:0] p1, input logic [5:0] p2,
                                        input logic r1, input logic r2, input logic [63:0] imm);
        logic [247:0] u;
        logic [63:0]  f;
        u = '0;
        f = {$urandom(), $urandom()};
        u[176:117] = f[59:0];
        u[38:0]    = f[38:0];
        u[247:241] = rid; u[240:177] = pc; u[116:111] = p1; u[110:105] = p2;
        u[104] = r1; u[103] = r2; u[102:39] = imm;
        return u;
    endfunction

    function automatic bit yng(input logic [6:0] id, input logic [6:0] f);
        int wrap_diff;
        wrap_diff = ((int'(id) / 64) != (int'(f) / 64)) ? 1 : 0;
        return (wrap_diff != 0) != ((int'(id) % 64) > (int'(f) % 64));
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        tick(); tick();
        #2;
        tests++; if (exu_valid !== 1'b0) begin fails++; $display("FAIL reset_exu_valid got=%b want=0", exu_valid); end
        tests++; if (isq_ready !== 1'b1) begin fails++; $display("FAIL reset_isq_ready got=%b want=1", isq_ready); end
        tests++; if (exu_data !== '0 || exu_src1 !== '0 || exu_src2 !== '0) begin
            fails++; $display("FAIL reset_outputs data=%h src1=%h src2=%h want 0", exu_data, exu_src1, exu_src2); end
        tests++; if (prf_rd0_idx !== 6'd0 || prf_rd1_idx !== 6'd0) begin
            fails++; $display("FAIL reset_prf_idx got=%0d/%0d want 0/0", prf_rd0_idx, prf_rd1_idx); end
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [247:0] u[3];
        bit exp_v;
        for (int i = 0; i < 3; i++) u[i] = mk(7'(i + 1), 64'h1000 + 64'(i), 6'd5, 6'd6, 1, 1, 64'h0);
        idle_inputs();
        prf_rd0_data = 64'h11; prf_rd1_data = 64'h22;
        for (int c = 0; c < 6; c++) begin
            isq_valid = (c < 3);
            isq_data  = (c < 3) ? u[c] : '0;
            #2;
            tests++; if (isq_ready !== 1'b1) begin fails++; $display("FAIL b2b_isq_ready c=%0d got=%b want=1", c, isq_ready); end
            if (c < 3) begin
                tests++; if (prf_rd0_idx !== 6'd5 || prf_rd1_idx !== 6'd6) begin
                    fails++; $display("FAIL b2b_prf_idx c=%0d got=%0d/%0d want 5/6", c, prf_rd0_idx, prf_rd1_idx); end
            end
            exp_v = (c >= 2 && c < 5);
            tests++; if (exu_valid !== exp_v) begin fails++; $display("FAIL b2b_exu_valid c=%0d got=%b want=%b", c, exu_valid, exp_v); end
            if (exp_v) begin
                tests++; if (exu_data !== u[c-2]) begin fails++; $display("FAIL b2b_data c=%0d got=%h want=%h", c, exu_data, u[c-2]); end
                tests++; if (exu_src1 !== 64'h11 || exu_src2 !== 64'h22) begin
                    fails++; $display("FAIL b2b_src c=%0d got=%h/%h want 11/22", c, exu_src1, exu_src2); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        logic [247:0] u;
        u = mk(7'h20, 64'h0, 6'd9, 6'd3, 1, 1, 64'h0);
        idle_inputs();
        isq_valid = 1; isq_data = u; wb_valid = 1; wb_prd = 6'd9; wb_data = 64'hABCD;
        tick();
        isq_valid = 0; wb_valid = 0; wb_data = 64'h5555;
        tick();
        #2;
        tests++; if (exu_valid !== 1'b1) begin fails++; $display("FAIL byp_exu_valid got=%b want=1", exu_valid); end
        tests++; if (exu_src1 !== 64'hABCD) begin fails++; $display("FAIL byp_src1 got=%h want=abcd", exu_src1); end
        tests++; if (exu_src2 !== 64'h0) begin fails++; $display("FAIL byp_src2 got=%h want=0", exu_src2); end
        tick();
        #2;
        tests++; if (exu_valid !== 1'b0) begin fails++; $display("FAIL byp_drain got=%b want=0", exu_valid); end
        tick();
    endtask

    task automatic test_stall_hold();
        logic [247:0] ua, ub, uc;
        ua = mk(7'h30, 64'h0, 6'd7, 6'd8, 1, 1, 64'h0);
        ub = mk(7'h31, 64'h0, 6'd7, 6'd8, 1, 1, 64'h0);
        uc = mk(7'h32, 64'h0, 6'd7, 6'd8, 1, 1, 64'h0);
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            exu_ready = (c >= 7);
            isq_valid = (c < 7);
            isq_data  = (c == 0) ? ua : (c == 1) ? ub : uc;
            if (c == 1) begin prf_rd0_data = 64'h77; prf_rd1_data = 64'h88; end
            else if (c == 2) begin prf_rd0_data = 64'h55; prf_rd1_data = 64'h66; end
            else begin prf_rd0_data = {$urandom(), $urandom()}; prf_rd1_data = {$urandom(), $urandom()}; end
            #2;
            if (c >= 2 && c <= 7) begin
                tests++; if (exu_valid !== 1'b1 || exu_data !== ua) begin
                    fails++; $display("FAIL stall_hold_a c=%0d valid=%b data=%h want 1/%h", c, exu_valid, exu_data, ua); end
                tests++; if (exu_src1 !== 64'h77 || exu_src2 !== 64'h88) begin
                    fails++; $display("FAIL stall_src_a c=%0d got=%h/%h want 77/88", c, exu_src1, exu_src2); end
                tests++; if (isq_ready !== (c == 7)) begin
                    fails++; $display("FAIL stall_isq_ready c=%0d got=%b want=%b", c, isq_ready, c == 7); end
            end else if (c == 8) begin
                tests++; if (exu_valid !== 1'b1 || exu_data !== ub || exu_src1 !== 64'h55 || exu_src2 !== 64'h66) begin
                    fails++; $display("FAIL stall_b valid=%b src=%h/%h want 1/55/66", exu_valid, exu_src1, exu_src2); end
            end else if (c == 9) begin
                tests++; if (exu_valid !== 1'b0) begin fails++; $display("FAIL stall_drain got=%b want=0", exu_valid); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_imm_zero();
        logic [247:0] ua, ub;
        ua = mk(7'h40, 64'h0, 6'd0, 6'd4, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0);
        ub = mk(7'h41, 64'h1234_5678_9ABC_DEF0, 6'd0, 6'd4, 0, 1, 64'h0);
        idle_inputs();
        prf_rd0_data = 64'hDEAD; prf_rd1_data = 64'hBEEF;
        isq_valid = 1; isq_data = ua;
        tick();
        isq_data = ub;
        tick();
        isq_valid = 0;
        #2;
        tests++; if (exu_valid !== 1'b1 || exu_src1 !== 64'h0 || exu_src2 !== 64'hFFFF_FFFF_FFFF_FFF0) begin
            fails++; $display("FAIL imm_zero valid=%b src=%h/%h want 1/0/fff..f0", exu_valid, exu_src1, exu_src2); end
        tick();
        #2;
        tests++; if (exu_valid !== 1'b1 || exu_src1 !== 64'h1234_5678_9ABC_DEF0 || exu_src2 !== 64'hBEEF) begin
            fails++; $display("FAIL pc_src1 valid=%b src=%h/%h want 1/123456789abcdef0/beef", exu_valid, exu_src1, exu_src2); end
        tick();
        idle_inputs();
    endtask

    task automatic test_flush_wrap();
        logic [247:0] ua, ub;
        ua = mk(7'h7E, 64'h0, 6'd1, 6'd2, 1, 1, 64'h0);
        ub = mk(7'h01, 64'h0, 6'd1, 6'd2, 1, 1, 64'h0);
        idle_inputs();
        exu_ready = 0;
        isq_valid = 1; isq_data = ua;
        tick();
        isq_data = ub;
        tick();
        isq_valid = 0; flush_valid = 1; flush_robid = 7'h7F;
        #2;
        tests++; if (exu_valid !== 1'b1 || exu_data[247:241] !== 7'h7E) begin
            fails++; $display("FAIL wrap_s2_survive valid=%b robid=%h want 1/7e", exu_valid, exu_data[247:241]); end
        tick();
        flush_valid = 0; exu_ready = 1;
        #2;
        tests++; if (exu_valid !== 1'b1 || exu_data !== ua) begin
            fails++; $display("FAIL wrap_s2_issue valid=%b robid=%h want 1/7e", exu_valid, exu_data[247:241]); end
        tick();
        #2;
        tests++; if (exu_valid !== 1'b0 || isq_ready !== 1'b1) begin
            fails++; $display("FAIL wrap_s1_dropped valid=%b ready=%b want 0/1", exu_valid, isq_ready); end
        tick();
        #2;
        tests++; if (exu_valid !== 1'b0) begin fails++; $display("FAIL wrap_empty got=%b want=0", exu_valid); end
        tick();
    endtask

    task automatic test_flush_equal();
        logic [247:0] ua, ub, uc;
        ua = mk(7'h10, 64'h0, 6'd1, 6'd2, 1, 1, 64'h0);
        ub = mk(7'h11, 64'h0, 6'd1, 6'd2, 1, 1, 64'h0);
        uc = mk(7'h12, 64'h0, 6'd1, 6'd2, 1, 1, 64'h0);
        idle_inputs();
        exu_ready = 0;
        isq_valid = 1; isq_data = ua;
        tick();
        isq_data = ub;
        tick();
        isq_data = uc; flush_valid = 1; flush_robid = 7'h10; exu_ready = 1;
        #2;
        tests++; if (exu_valid !== 1'b1 || exu_data !== ua) begin
            fails++; $display("FAIL eq_s2_issue valid=%b robid=%h want 1/10", exu_valid, exu_data[247:241]); end
        tests++; if (isq_ready !== 1'b1) begin fails++; $display("FAIL eq_isq_ready got=%b want=1", isq_ready); end
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #2;
            tests++; if (exu_valid !== 1'b0 || isq_ready !== 1'b1) begin
                fails++; $display("FAIL eq_pipe_empty c=%0d valid=%b ready=%b want 0/1", c, exu_valid, isq_ready); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        exu_ready = 0; isq_valid = 1;
        isq_data = mk(7'h05, 64'h0, 6'd3, 6'd4, 1, 1, 64'h0);
        tick(); tick(); tick();
        #1 reset_n = 0;
        #1;
        tests++; if (exu_valid !== 1'b0 || isq_ready !== 1'b1 || exu_data !== '0 || exu_src1 !== '0) begin
            fails++; $display("FAIL reset_mid valid=%b ready=%b data=%h want 0/1/0", exu_valid, isq_ready, exu_data); end
        tick();
        idle_inputs();
        reset_n = 1;
        tick();
        #2;
        tests++; if (exu_valid !== 1'b0) begin fails++; $display("FAIL reset_mid_after got=%b want=0", exu_valid); end
        tick();
    endtask

    task automatic test_random(input int n);
        bit m1v = 0, m1first = 0, m1b1 = 0, m1b2 = 0, m2v = 0;
        logic [247:0] m1d = '0, m2d = '0;
        logic [63:0] m1bv1 = '0, m1bv2 = '0, m1o1 = '0, m1o2 = '0, m2s1 = '0, m2s2 = '0;
        bit e_rdy, e_ev, k1, k2, ki, adv;
        for (int c = 0; c < n + 12; c++) begin
            if (c < n) begin
                isq_valid = ($urandom_range(9) < 7);
                isq_data  = mk(7'($urandom), {$urandom(), $urandom()}, 6'($urandom_range(7)), 6'($urandom_range(7)),
                               1'($urandom), 1'($urandom), {$urandom(), $urandom()});
                exu_ready   = ($urandom_range(9) < 6);
                wb_valid    = ($urandom_range(9) < 3);
                wb_prd      = 6'($urandom_range(7));
                wb_data     = {$urandom(), $urandom()};
                flush_valid = ($urandom_range(99) < 8);
                flush_robid = 7'($urandom);
            end else begin
                isq_valid = 0; exu_ready = 1; wb_valid = 0; flush_valid = 0;
            end
            prf_rd0_data = {$urandom(), $urandom()};
            prf_rd1_data = {$urandom(), $urandom()};
            #2;
            k2 = flush_valid && m2v && yng(m2d[247:241], flush_robid);
            k1 = flush_valid && m1v && yng(m1d[247:241], flush_robid);
            ki = flush_valid && yng(isq_data[247:241], flush_robid);
            e_rdy = !m1v || !m2v || exu_ready;
            e_ev  = m2v && !k2;
            tests++; if (isq_ready !== e_rdy) begin fails++; $display("FAIL rnd_isq_ready c=%0d got=%b want=%b", c, isq_ready, e_rdy); end
            tests++; if (exu_valid !== e_ev) begin fails++; $display("FAIL rnd_exu_valid c=%0d got=%b want=%b", c, exu_valid, e_ev); end
            tests++; if (prf_rd0_idx !== isq_data[116:111] || prf_rd1_idx !== isq_data[110:105]) begin
                fails++; $display("FAIL rnd_prf_idx c=%0d got=%0d/%0d", c, prf_rd0_idx, prf_rd1_idx); end
            if (e_ev) begin
                tests++; if (exu_data !== m2d || exu_src1 !== m2s1 || exu_src2 !== m2s2) begin
                    fails++; $display("FAIL rnd_exu_payload c=%0d robid=%h src=%h/%h want %h/%h/%h",
                                      c, exu_data[247:241], exu_src1, exu_src2, m2d[247:241], m2s1, m2s2); end
            end
            if (m1v && m1first) begin
                m1o1 = (m1d[116:111] == 0) ? 64'h0 : m1b1 ? m1bv1 : prf_rd0_data;
                m1o2 = (m1d[110:105] == 0) ? 64'h0 : m1b2 ? m1bv2 : prf_rd1_data;
                m1first = 0;
            end
            adv = m1v && (!m2v || exu_ready);
            if (adv && !k1) begin
                m2v = 1; m2d = m1d;
                m2s1 = m1d[104] ? m1o1 : m1d[240:177];
                m2s2 = m1d[103] ? m1o2 : m1d[102:39];
            end else if ((e_ev && exu_ready) || k2) begin
                m2v = 0;
            end
            if (isq_valid && e_rdy && !ki) begin
                m1v = 1; m1d = isq_data; m1first = 1;
                m1b1 = wb_valid && (wb_prd == isq_data[116:111]); m1bv1 = wb_data;
                m1b2 = wb_valid && (wb_prd == isq_data[110:105]); m1bv2 = wb_data;
            end else if (adv || k1) begin
                m1v = 0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_bypass();
        test_stall_hold();
        test_imm_zero();
        test_flush_wrap();
        test_flush_equal();
        test_random(800);
        test_reset_mid();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
